instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side partner of the single-cycle CPU's instruction memory. The CPU only ever reads that memory (InsMemRW=0); this block is the writer.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the CPU stalled for the duration of a load.

Parameters:
- ADDR_WIDTH, 8, width of the word index; instruction memory depth is 2**ADDR_WIDTH words.
- MAX_WORDS, 64, largest legal load length in words; must be ≤ 2**ADDR_WIDTH.
- BASE_ADDR, 32'h00000000, byte address of the first word written.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE.
- word_count  input  ADDR_WIDTH+1  number of words to load; latched when start is accepted.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- InsMemRW  output  1  instruction-memory write strobe; 1 = write, 0 = read.
- IAddr  output  32  instruction-memory byte address.
- IDataIn  output  32  instruction word to be written.
- cpu_hold  output  1  while 1, the CPU must not advance the PC (gates PCWre).
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse after the last word is written.
- error  output  1  last start carried an illegal word_count; sticky.
- checksum  output  32  XOR of all words written in the current or last load.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; byte_ready=0, InsMemRW=0, IAddr=BASE_ADDR, IDataIn=0, cpu_hold=0, busy=0, done=0, error=0, checksum=0; byte counter=0, word index=0.
  - Reset asserted mid-load aborts the load immediately: InsMemRW drops with no clock edge, and a partially assembled word is discarded.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: byte_ready=0, busy=0, cpu_hold=0. On start=1:
  - If word_count==0 or word_count>MAX_WORDS: error←1 and stay in IDLE. No write occurs and done is not pulsed.
  - Otherwise: latch word_count, error←0, checksum←0, word index←0, byte counter←0, go to RECV.
- RECV: byte_ready=1, busy=1, cpu_hold=1.
  - A byte is accepted on a rising edge where byte_valid&&byte_ready.
  - Byte k of a word (k=0..3) goes to bits [31-8k:24-8k]; the first byte is the MSB.
  - On acceptance of the 4th byte: go to WRITE. byte_valid without acceptance is ignored; there is no timeout.
- WRITE: exactly one cycle.
  - InsMemRW=1, IAddr=BASE_ADDR+4*index, IDataIn=assembled word; byte_ready=0.
  - At the edge ending WRITE: checksum←checksum^word, index←index+1, byte counter←0.
  - Next state is DONE if index+1==latched count, else RECV.
  - InsMemRW is 0 in every other state.
- DONE: one cycle; done=1, busy=1, cpu_hold=1, byte_ready=0. Next state is IDLE. done=0 in every other state.
- start is ignored outside IDLE. word_count changes after latching have no effect.
- Write latency: the 4th accepted byte is followed by InsMemRW=1 in the next cycle. Minimum load time is 5*N+1 cycles for N words.
- IAddr and IDataIn hold their last values outside WRITE.
- Address arithmetic is 32-bit. The index never wraps because MAX_WORDS ≤ 2**ADDR_WIDTH.
- checksum and error hold until the next accepted start or reset.

Test Plan:
- Reset, start with word_count=1; stream 8'h20,8'h01,8'h00,8'h05 with byte_valid held high -> exactly one cycle with InsMemRW=1, IAddr=0, IDataIn=32'h20010005; done pulses the next cycle; checksum=32'h20010005; cpu_hold=1 throughout.
- word_count=3, words 32'h00000001, 32'h00000002, 32'h00000004 streamed with byte_valid toggling every other cycle -> writes land at IAddr 0, 4, 8 in order; checksum=32'h00000007; byte_ready=0 during each WRITE cycle.
- start with word_count=0, then start with word_count=65 -> error=1, no InsMemRW pulse, busy stays 0; a following legal start clears error.
- Reset pulled low after 6 bytes of a 2-word load -> InsMemRW=0, busy=0, cpu_hold=0 before the next edge; the restarted load writes its first word at IAddr=0.
- start asserted while in RECV with word_count=5 -> ignored; the original count of 2 completes with exactly 2 writes.
- word_count=MAX_WORDS=64 -> the last write is at IAddr=252 and done follows; the total load time with continuous byte_valid is 321 cycles after start is accepted.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: write-side partner of the CPU instruction memory.
// Takes a byte stream over a valid/ready handshake and packs it into
// big-endian 32-bit words. Each word goes to consecutive word addresses
// starting at BASE_ADDR. The CPU is held for the whole load, and the
// block keeps an XOR checksum of every word it writes.
module instr_mem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          MAX_WORDS  = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  InsMemRW,
    output logic [31:0]           IAddr,
    output logic [31:0]           IDataIn,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH:0]   cnt_q,        cnt_d;
    logic [ADDR_WIDTH:0]   idx_q,        idx_d;
    logic [1:0]            bcnt_q,       bcnt_d;
    logic [31:0]           word_q,       word_d;
    logic [31:0]           iaddr_q,      iaddr_d;
    logic [31:0]           idata_q,      idata_d;
    logic [31:0]           checksum_q,   checksum_d;
    logic                  insrw_q,      insrw_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic                  error_q,      error_d;

    logic                  accept_s;
    logic [31:0]           word_next_s;
    logic [ADDR_WIDTH:0]   idx_inc_s;

    // Handshake, shifted word and incremented index shared by the next-state logic.
    always_comb begin
        accept_s    = byte_valid && byte_ready_q;
        word_next_s = {word_q[23:0], byte_data};
        idx_inc_s   = idx_q + CNT_ONE;
    end

    // Next-state logic for the FSM, datapath and registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        iaddr_d    = iaddr_q;
        idata_d    = idata_q;
        checksum_d = checksum_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((word_count == '0) || (word_count > MAX_CNT)) begin
                        // Illegal length: flag it and do not touch memory.
                        error_d = 1'b1;
                    end else begin
                        cnt_d      = word_count;
                        error_d    = 1'b0;
                        checksum_d = 32'h0000_0000;
                        idx_d      = '0;
                        bcnt_d     = 2'd0;
                        word_d     = 32'h0000_0000;
                        state_d    = S_RECV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (accept_s) begin
                    word_d = word_next_s;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // The fourth byte completes the word. Stage it for the write cycle.
                        iaddr_d = BASE_ADDR + (32'(idx_q) << 2);
                        idata_d = word_next_s;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RECV;
                    end
                end else begin
                    state_d = S_RECV;
                end
            end
            S_WRITE: begin
                checksum_d = checksum_q ^ idata_q;
                idx_d      = idx_inc_s;
                bcnt_d     = 2'd0;
                word_d     = 32'h0000_0000;
                if (idx_inc_s == cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they align with state_q.
        insrw_d      = (state_d == S_WRITE);
        byte_ready_d = (state_d == S_RECV);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers. An asynchronous reset aborts any load in progress.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            bcnt_q       <= 2'd0;
            word_q       <= 32'h0000_0000;
            iaddr_q      <= BASE_ADDR;
            idata_q      <= 32'h0000_0000;
            checksum_q   <= 32'h0000_0000;
            insrw_q      <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
            word_q       <= word_d;
            iaddr_q      <= iaddr_d;
            idata_q      <= idata_d;
            checksum_q   <= checksum_d;
            insrw_q      <= insrw_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign InsMemRW   = insrw_q;
    assign IAddr      = iaddr_q;
    assign IDataIn    = idata_q;
    assign cpu_hold   = busy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader. A reference model describes each load
// as the list of (address, word) writes it must produce plus the XOR
// checksum. A negedge monitor records what the DUT actually does, and the
// bench compares the two.
module tb_instr_mem_loader;

    localparam int          AW   = 8;
    localparam int          MAXW = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready, InsMemRW, cpu_hold, busy, done, error;
    logic [31:0]   IAddr, IDataIn, checksum;

    instr_mem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .InsMemRW(InsMemRW), .IAddr(IAddr), .IDataIn(IDataIn), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] words[$];
    int          done_cnt = 0;
    int          br_bad = 0;
    int          hold_bad = 0;
    int          cyc = 0;
    int          c0 = 0;
    int          idle_cyc = 0;
    int          done_cyc = 0;
    logic        busy_prev = 1'b0;

    // Cycle counter: increments on every rising edge.
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: records writes, done pulses and handshake anomalies.
    always @(negedge CLK) begin
        if (InsMemRW === 1'b1) begin
            wr_addr.push_back(IAddr);
            wr_data.push_back(IDataIn);
            if (byte_ready !== 1'b0) br_bad++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cpu_hold !== busy) hold_bad++;
        if (busy_prev === 1'b1 && busy === 1'b0) idle_cyc = cyc;
        busy_prev = busy;
    end

    // Watchdog: stops a run that is stuck.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int n);
        @(negedge CLK);
        start = 1'b1;
        word_count = n[AW:0];
        @(posedge CLK);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic stream_byte(input logic [7:0] b, input bit toggle);
        bit sent = 1'b0;
        bit ph = 1'b0;
        bit v;
        int guard = 0;
        while (!sent && guard < 200) begin
            @(negedge CLK);
            guard++;
            v = toggle ? ph : 1'b1;
            ph = !ph;
            byte_valid = v;
            byte_data = v ? b : 8'($urandom);
            if (v && byte_ready === 1'b1) begin
                sent = 1'b1;
                @(posedge CLK);
            end
        end
        chk("stream_timeout", {31'd0, sent}, 32'd1);
    endtask

    task automatic stream_word(input logic [31:0] w, input bit toggle);
        for (int k = 0; k < 4; k++) stream_byte(w[31-8*k -: 8], toggle);
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge CLK);
            g++;
        end while (busy !== 1'b0 && g < 1000);
        #1;
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Reference model: XOR of the words in the load.
    function automatic logic [31:0] model_ck();
        logic [31:0] c = 32'h0;
        foreach (words[i]) c = c ^ words[i];
        return c;
    endfunction

    // Runs one full legal load of the words currently in `words`.
    task automatic run_load(input bit toggle, input bit mid_start);
        int n = words.size();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        br_bad = 0;
        hold_bad = 0;
        do_start(n);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_err_clr", {31'd0, error}, 32'd0);
        chk("start_ck_clr", checksum, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (mid_start && i == 1) begin
                #1;
                start = 1'b1;
                word_count = 9'd5;
            end
            stream_word(words[i], toggle);
            if (mid_start && i == 1) begin
                #1;
                start = 1'b0;
            end
        end
        @(negedge CLK);
        byte_valid = 1'b0;
        wait_idle();
        chk("n_writes", wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            chk("wr_addr", wr_addr[i], BASE + 32'(4 * i));
            chk("wr_data", wr_data[i], words[i]);
        end
        chk("checksum", checksum, model_ck());
        chk("done_pulses", done_cnt, 1);
        chk("br_in_write", br_bad, 0);
        chk("hold_eq_busy", hold_bad, 0);
        chk("end_error", {31'd0, error}, 32'd0);
        chk("end_rw", {31'd0, InsMemRW}, 32'd0);
        if (!toggle) begin
            chk("done_time", done_cyc - c0, 5 * n);
            chk("load_time", idle_cyc - c0, 5 * n + 1);
        end
    endtask

    initial begin
        logic [31:0] prev_ck;
        // Reset state.
        #12;
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_rw", {31'd0, InsMemRW}, 32'd0);
        chk("rst_iaddr", IAddr, BASE);
        chk("rst_idata", IDataIn, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_ck", checksum, 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        // Single word, continuous bytes.
        words = '{32'h20010005};
        run_load(1'b0, 1'b0);

        // Three words, byte_valid toggling.
        words = '{32'h00000001, 32'h00000002, 32'h00000004};
        run_load(1'b1, 1'b0);
        chk("ck_1_2_4", checksum, 32'h00000007);

        // Illegal lengths: error set, nothing written, checksum kept.
        prev_ck = checksum;
        wr_addr.delete();
        done_cnt = 0;
        do_start(0);
        chk("ill0_err", {31'd0, error}, 32'd1);
        chk("ill0_busy", {31'd0, busy}, 32'd0);
        do_start(65);
        chk("ill65_err", {31'd0, error}, 32'd1);
        do_start(int'($urandom_range(66, 511)));
        repeat (4) @(negedge CLK);
        chk("ill_err_hold", {31'd0, error}, 32'd1);
        chk("ill_busy", {31'd0, busy}, 32'd0);
        chk("ill_writes", wr_addr.size(), 0);
        chk("ill_done", done_cnt, 0);
        chk("ill_ck_hold", checksum, prev_ck);
        words = '{$urandom, $urandom};
        run_load(1'b0, 1'b0);

        // Reset after 6 bytes of a 2-word load.
        words = '{$urandom, $urandom};
        do_start(2);
        stream_word(words[0], 1'b0);
        stream_byte(words[1][31:24], 1'b0);
        stream_byte(words[1][23:16], 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_rst_rw", {31'd0, InsMemRW}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("mid_rst_ck", checksum, 32'd0);
        byte_valid = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        words = '{$urandom};
        run_load(1'b0, 1'b0);

        // Reset during the WRITE cycle drops InsMemRW without a clock edge.
        words = '{$urandom};
        do_start(1);
        stream_word(words[0], 1'b0);
        #2;
        chk("wr_rw_high", {31'd0, InsMemRW}, 32'd1);
        chk("wr_ready_low", {31'd0, byte_ready}, 32'd0);
        Reset = 1'b0;
        #1;
        chk("wr_rst_rw", {31'd0, InsMemRW}, 32'd0);
        chk("wr_rst_iaddr", IAddr, BASE);
        byte_valid = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;

        // A start during RECV is ignored.
        words = '{$urandom, $urandom};
        run_load(1'b0, 1'b1);

        // Random loads.
        for (int r = 0; r < 3; r++) begin
            int n = int'($urandom_range(1, 8));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_load(bit'($urandom_range(0, 1)), 1'b0);
        end

        // Maximum length load.
        words.delete();
        for (int i = 0; i < MAXW; i++) words.push_back($urandom);
        run_load(1'b0, 1'b0);
        if (wr_addr.size() == MAXW) chk("last_addr", wr_addr[MAXW-1], 32'd252);
        else chk("last_addr_count", wr_addr.size(), MAXW);
        chk("max_time", idle_cyc - c0, 321);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
